// File: rtl/qdi_e1of4_sync_rx.sv
// qdi_e1of4_sync_rx
//   Clocked receiver for an e1of4 QDI channel. Acts as the four-phase
//   handshake partner on Rx/Rxe, decodes each 1-of-4 token to 2-bit binary
//   and buffers it in a circular FIFO behind a valid/ready interface.
//
// Parameters
//   DEPTH        FIFO entries, power of two, 2..16
//   SYNC_STAGES  synchronizer flops per rail, 2 or 3
//
// Ports
//   CLK, RESET   clock (rising edge), synchronous active-high reset
//   VDD, GND     supply pins, netlist connectivity only
//   Rx[3:0]      1-of-4 rails from upstream, asynchronous to CLK
//   Rxe          enable to upstream: 1 = ready for data, 0 = acknowledge
//   out_data     decoded token at FIFO head (undefined when out_valid=0)
//   out_valid    FIFO non-empty
//   out_ready    consumer pops head when out_valid & out_ready
//   count        FIFO occupancy
//   err          sticky illegal-codeword flag
//
// Build option
//   QDI_RX_ERR_CHECK_EN  defined: multi-hot rails in WAIT_DATA set err and are
//                        dropped. Undefined: err tied 0, multi-hot decoded by
//                        priority (highest rail wins).
module qdi_e1of4_sync_rx #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  inout  wire                     VDD,
  inout  wire                     GND,
  input  logic [3:0]              Rx,
  output logic                    Rxe,
  output logic [1:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    WAIT_DATA,
    WAIT_NEUTRAL,
    STALL
  } state_e;

  logic unused_supply;
  assign unused_supply = VDD ^ GND;

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    sync_d [SYNC_STAGES];
  state_e        state_q, state_d;
  logic          rxe_q, rxe_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [3:0]    rs;
  logic [1:0]    dec;
  logic          push, pop, valid;

  always_comb begin
    sync_d[0] = Rx;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rs = sync_q[SYNC_STAGES-1];

  // Priority decode; identical to the one-hot decode for legal codewords.
  always_comb begin
    dec = 2'b00;
    if (rs[3])      dec = 2'b11;
    else if (rs[2]) dec = 2'b10;
    else if (rs[1]) dec = 2'b01;
  end

  assign valid = (count_q != '0);
  assign pop   = valid & out_ready;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    err_d   = err_q;
    case (state_q)
      WAIT_DATA: begin
`ifdef QDI_RX_ERR_CHECK_EN
        if ($onehot(rs)) begin
          push    = 1'b1;
          state_d = WAIT_NEUTRAL;
        end else if (rs != '0) begin
          err_d   = 1'b1;
          state_d = WAIT_NEUTRAL;
        end
`else
        if (rs != '0) begin
          push    = 1'b1;
          state_d = WAIT_NEUTRAL;
        end
`endif
      end
      WAIT_NEUTRAL: begin
        if (rs == '0) begin
          state_d = (count_q != FULL_CNT) ? WAIT_DATA : STALL;
        end
      end
      STALL: begin
        if (count_q != FULL_CNT) state_d = WAIT_DATA;
      end
      default: state_d = WAIT_DATA;
    endcase
    // Rxe is registered from the next state, so it cannot glitch.
    rxe_d = (state_d == WAIT_DATA);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = dec;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      state_q  <= WAIT_DATA;
      rxe_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      rxe_q    <= rxe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign Rxe       = rxe_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = valid;
  assign count     = count_q;
`ifdef QDI_RX_ERR_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/qdi_e1of4_sync_rx.md
# qdi_e1of4_sync_rx

Clocked receiver that consumes the e1of4 output channel of the QDI register stage and bridges it into the synchronous domain. It acts as the four-phase handshake partner on the 1-of-4 rails and the enable line. Each received token is decoded to 2-bit binary and buffered in a small FIFO behind a valid/ready interface. The block sits directly downstream of the register's Rx/Rxe port and replaces the behavioural QDI-to-binary receiver when the register is integrated with clocked logic.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- SYNC_STAGES, 2, synchronizer flops per rail; 2 or 3
- CLK  input  1  system clock; all state on rising edge
- RESET  input  1  synchronous, active-high reset
- VDD, GND  inout  1  supply pins; netlist connectivity only, unused in RTL
- Rx  input  4  1-of-4 data rails from upstream; asynchronous to CLK
- Rxe  output  1  enable to upstream; 1 = ready for data, 0 = acknowledge
- out_data  output  2  decoded token at FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head when out_valid & out_ready
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- err  output  1  sticky illegal-codeword flag (see Configuration)

## Operation
- Rx passes through a SYNC_STAGES-deep synchronizer. rs denotes the last stage. The FSM uses rs only.
- Decode: Rx[0]→00, Rx[1]→01, Rx[2]→10, Rx[3]→11.
- FSM states:
  - WAIT_DATA (Rxe=1): on rs one-hot, push the decoded value and go to WAIT_NEUTRAL with Rxe=0. On rs=0, stay.
  - WAIT_NEUTRAL (Rxe=0): on rs=0 and count<DEPTH, go to WAIT_DATA with Rxe=1. On rs=0 and FIFO full, go to STALL. Otherwise stay.
  - STALL (Rxe=0): on count<DEPTH, go to WAIT_DATA with Rxe=1.
- Rxe is a registered output equal to 1 only in WAIT_DATA. It never glitches.
- Rxe rises only when at least one FIFO slot is free, so a push can never overflow.
- FIFO: circular buffer with wrapping read/write pointers.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop leaves count unchanged and keeps data ordering.
  - out_data is undefined when out_valid=0.
- Reset, including mid-handshake:
  - state=WAIT_DATA, Rxe=1, FIFO flushed, count=0, out_valid=0, err=0, synchronizer flops cleared.
  - Any partially received token is discarded.
  - Upstream is reset alongside and returns rails to neutral.

## Timing
- Rail rise sampled at edge t gives the push and Rxe fall at edge t+SYNC_STAGES; out_valid is high after that edge when the FIFO was empty.
- Rails neutral at edge t gives Rxe rise at edge t+SYNC_STAGES when not full.
- In STALL, a pop at edge t gives Rxe=1 after edge t+1.
- Full cycle throughput: one token per ≥2·(SYNC_STAGES+1) clocks plus upstream delays.
- count and out_valid are registered. The pop takes effect at the accepting edge.

## Configuration
- QDI_RX_ERR_CHECK_EN defined:
  - In WAIT_DATA, rs with more than one rail high sets err (sticky until RESET).
  - No push occurs, and the FSM waits for rs=0 before raising Rxe again via WAIT_NEUTRAL rules.
- Undefined:
  - err is tied 0.
  - A multi-hot rs is treated as valid and decoded by priority, highest rail wins.

## Test plan
- Reset: hold RESET 3 clocks with Rx=0000 -> Rxe=1, out_valid=0, count=0, err=0.
- Single token: Rx=1000 until Rxe=0, then Rx=0000 -> after SYNC_STAGES clocks Rxe=0 and out_data=11 with out_valid=1; Rxe returns to 1 SYNC_STAGES clocks after neutral.
- Ordering: send 01,10,00,11 with out_ready=1 -> out_data sequence 01,10,00,11, count never exceeds 1.
- Backpressure: out_ready=0, send DEPTH+1 tokens -> count=DEPTH, Rxe held 0 in STALL; one pop -> Rxe=1 next clock, the (DEPTH+1)th token is accepted, then drain in order.
- Simultaneous push/pop at count=2 -> count stays 2 and the head advances correctly.
- With QDI_RX_ERR_CHECK_EN: drive Rx=0011 -> err=1, no push, Rxe=0; after Rx=0000, Rxe returns to 1 and err stays 1 until RESET.
